// File: rtl/deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_pkg
// Description : Shared definitions for the serial-to-parallel deserializer:
//               FSM state encoding and default word width.
// Revision    : 1.0 - initial release
// ============================================================================
package deserializer_pkg;

    // Default number of bits per assembled word.
    localparam int unsigned c_DEFAULT_WORD_WIDTH = 8;

    // ST_IDLE  : not aligned to a word boundary, waiting for sync.
    // ST_SHIFT : aligned, collecting bits of the current word.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : deserializer_pkg
`default_nettype wire

// File: rtl/deserializer_shift.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_shift
// Description : Shift register and bit counter for the deserializer.
//               i_start begins a new word with i_sdi as its first bit;
//               i_shift appends i_sdi to the word in progress. o_word_next is
//               the register contents after this cycle's bit, so the parent
//               can capture a finished word on the edge sampling its last bit.
//               Bit order is MSB first unless DESERIALIZER_LSB_FIRST_EN is
//               defined, in which case the first bit ends up in bit 0.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_start            - begin a new word with i_sdi as bit 1
//               i_shift            - append i_sdi to the current word
//               i_sdi              - serial data bit
//               o_word_next        - word value including this cycle's bit
//               o_count            - bits collected so far (0..WORD_WIDTH-1)
//               o_complete         - this cycle's bit completes the word
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer_shift
    import deserializer_pkg::*;
#(
    parameter int WORD_WIDTH = c_DEFAULT_WORD_WIDTH,
    localparam int CNT_W     = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_shift,
    input  logic                  i_sdi,
    output logic [WORD_WIDTH-1:0] o_word_next,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_complete
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WORD_WIDTH - 1);

    logic [WORD_WIDTH-1:0] r_sr;
    logic [CNT_W-1:0]      r_count;
    logic [WORD_WIDTH-1:0] w_base;
    logic [WORD_WIDTH-1:0] w_shifted;

    // A new word starts from an empty register so stale bits of an
    // abandoned partial word can never leak into the result.
    always_comb begin
        w_base = i_start ? '0 : r_sr;
`ifdef DESERIALIZER_LSB_FIRST_EN
        w_shifted = {i_sdi, w_base[WORD_WIDTH-1:1]};
`else
        w_shifted = {w_base[WORD_WIDTH-2:0], i_sdi};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr    <= '0;
            r_count <= '0;
        end else if (i_start) begin
            r_sr    <= w_shifted;
            r_count <= CNT_W'(1);
        end else if (i_shift) begin
            r_sr    <= w_shifted;
            // Wrap to 0 on the last bit so the next word follows with no sync.
            r_count <= (r_count == c_LAST) ? '0 : r_count + CNT_W'(1);
        end
    end

    // A start can never complete a word because WORD_WIDTH >= 2.
    assign o_word_next = w_shifted;
    assign o_count     = r_count;
    assign o_complete  = i_shift && (r_count == c_LAST);

endmodule : deserializer_shift
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Serial-to-parallel converter. Bits qualified by bit_en are
//               assembled into WORD_WIDTH-bit words; sync marks the first bit
//               of a word. Completed words are presented on data/valid with a
//               valid/ready handshake. overrun pulses when a finished word is
//               dropped because the output register is still occupied;
//               sync_err pulses when sync arrives mid-word.
//               Define DESERIALIZER_LSB_FIRST_EN for LSB-first bit order
//               (default build is MSB first).
// Ports       : clk, rst  - clock, synchronous active-high reset
//               sdi       - serial data bit
//               bit_en    - sdi carries a valid bit this cycle
//               sync      - with bit_en, sdi is the first bit of a word
//               valid     - data holds a complete word
//               ready     - consumer accepts data when valid && ready
//               data      - assembled word
//               overrun   - pulse: completed word dropped (output full)
//               sync_err  - pulse: partial word discarded by mid-word sync
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer
    import deserializer_pkg::*;
#(
    parameter int WORD_WIDTH = c_DEFAULT_WORD_WIDTH,
    localparam int CNT_W     = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sdi,
    input  logic                  bit_en,
    input  logic                  sync,
    output logic                  valid,
    input  logic                  ready,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  overrun,
    output logic                  sync_err
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_start;
    logic                  w_shift;
    logic                  w_sync_err;
    logic                  w_complete;
    logic [WORD_WIDTH-1:0] w_word;
    logic [CNT_W-1:0]      w_count;

    logic [WORD_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_sync_err;

    deserializer_shift #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_shift     (w_shift),
        .i_sdi       (sdi),
        .o_word_next (w_word),
        .o_count     (w_count),
        .o_complete  (w_complete)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Nothing happens without bit_en. A sync in SHIFT restarts the word; it
    // is only an error if bits of the current word were already collected.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_sync_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bit_en && sync) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_en) begin
                    if (sync) begin
                        w_start    = 1'b1;
                        w_sync_err = (w_count != '0);
                    end else begin
                        w_shift    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output register: a new word may load when the register is empty or is
    // being drained this same cycle; otherwise the new word is dropped.
    // Resync does not touch the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_overrun  <= 1'b0;
            r_sync_err <= w_sync_err;
            if (w_complete) begin
                if (!r_valid || ready) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid    = r_valid;
    assign data     = r_data;
    assign overrun  = r_overrun;
    assign sync_err = r_sync_err;

endmodule : deserializer
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer
// Description : Self-checking bench for deserializer (WORD_WIDTH = 8).
//               Expected words are queued as stimulus is issued; a monitor
//               pops and compares on every valid && ready beat, and counts
//               overrun / sync_err pulse cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

    localparam int c_W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           sdi;
    logic           bit_en;
    logic           sync;
    logic           valid;
    logic           ready;
    logic [c_W-1:0] data;
    logic           overrun;
    logic           sync_err;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             ov_cnt  = 0;
    int             se_cnt  = 0;
    bit             mon_en  = 1'b0;
    logic [c_W-1:0] exp_q[$];

    deserializer #(
        .WORD_WIDTH (c_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sdi      (sdi),
        .bit_en   (bit_en),
        .sync     (sync),
        .valid    (valid),
        .ready    (ready),
        .data     (data),
        .overrun  (overrun),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Time-ordered bit sequence for a word value: s[7] is sent first.
    function automatic logic [c_W-1:0] ord(input logic [c_W-1:0] w);
        logic [c_W-1:0] r;
`ifdef DESERIALIZER_LSB_FIRST_EN
        for (int i = 0; i < c_W; i++) r[i] = w[c_W-1-i];
`else
        r = w;
`endif
        return r;
    endfunction

    // Send bits from..from+n-1 of time-ordered sequence s.
    task automatic send_bits(input logic [c_W-1:0] s, input int from, input int n,
                             input bit sync_first, input bit gaps);
        for (int k = from; k < from + n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bit_en = 1'b0;
                    sync   = 1'($urandom_range(0, 1));
                    sdi    = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            bit_en = 1'b1;
            sdi    = s[c_W-1-k];
            sync   = (k == 0) && sync_first;
            tick();
        end
        bit_en = 1'b0;
        sync   = 1'b0;
        sdi    = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (overrun)  ov_cnt++;
            if (sync_err) se_cnt++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, expected no word", data);
                end else begin
                    check("word", 32'(data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [c_W-1:0] exp_raw;
        rst = 1'b1; sdi = 1'b0; bit_en = 1'b0; sync = 1'b0; ready = 1'b1;
        repeat (3) tick();
        check("reset_valid",    32'(valid),    32'd0);
        check("reset_data",     32'(data),     32'd0);
        check("reset_overrun",  32'(overrun),  32'd0);
        check("reset_sync_err", 32'(sync_err), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single word 0xA5, valid for exactly one cycle after bit 8.
        exp_q.push_back(8'hA5);
        send_bits(ord(8'hA5), 0, 8, 1'b1, 1'b0);
        check("a5_valid", 32'(valid), 32'd1);
        check("a5_data",  32'(data),  32'hA5);
        tick();
        check("a5_valid_drop", 32'(valid), 32'd0);

        // Back-to-back words, sync only on the first, random gaps.
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_bits(ord(8'h3C), 0, 8, 1'b1, 1'b1);
        send_bits(ord(8'hC3), 0, 8, 1'b0, 1'b1);
        repeat (2) tick();

        // Overrun: 0x11 held, 0x22 dropped.
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_bits(ord(8'h11), 0, 8, 1'b1, 1'b0);
        send_bits(ord(8'h22), 0, 8, 1'b0, 1'b0);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_data",  32'(data),    32'h11);
        check("ovr_valid", 32'(valid),   32'd1);
        tick();
        check("ovr_pulse_end", 32'(overrun), 32'd0);
        ready = 1'b1;
        tick();
        check("ovr_valid_drop", 32'(valid), 32'd0);

        // Mid-word sync at bit 5 discards the partial word.
        send_bits(ord(8'hF0), 0, 4, 1'b1, 1'b0);
        exp_q.push_back(8'h5A);
        send_bits(ord(8'h5A), 0, 1, 1'b1, 1'b0);
        check("sync_err_pulse", 32'(sync_err), 32'd1);
        send_bits(ord(8'h5A), 1, 7, 1'b0, 1'b0);
        repeat (2) tick();

        // Raw stream 0,0,0,0,0,0,0,1 in time order.
`ifdef DESERIALIZER_LSB_FIRST_EN
        exp_raw = 8'h80;
`else
        exp_raw = 8'h01;
`endif
        exp_q.push_back(exp_raw);
        send_bits(8'b0000_0001, 0, 8, 1'b1, 1'b0);
        repeat (2) tick();

        // Reset mid-word with a pending word.
        ready = 1'b0;
        send_bits(ord(8'h77), 0, 8, 1'b1, 1'b0);
        send_bits(ord(8'h0F), 0, 4, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data",  32'(data),  32'd0);
        ready = 1'b1;
        send_bits(ord(8'hFF), 0, 8, 1'b0, 1'b0);
        tick();
        check("nosync_valid", 32'(valid), 32'd0);
        exp_q.push_back(8'h42);
        send_bits(ord(8'h42), 0, 8, 1'b1, 1'b0);
        repeat (3) tick();

        check("overrun_pulses",  32'(ov_cnt),       32'd1);
        check("sync_err_pulses", 32'(se_cnt),       32'd1);
        check("words_pending",   32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_deserializer
`default_nettype wire
